regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 98 +++++++++
 1 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : 31 x WIDTH register file (r0 hard-wired zero) with write bypass
//            and a pending-write scoreboard that raises stall on hazards.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_writeEnable,
    input  logic [4:0]       ctrl_writeReg,
    input  logic [WIDTH-1:0] data_writeReg,
    input  logic [4:0]       ctrl_readRegA,
    input  logic [4:0]       ctrl_readRegB,
    input  logic             sb_set,
    input  logic [4:0]       sb_setReg,
    output logic [WIDTH-1:0] data_readRegA,
    output logic [WIDTH-1:0] data_readRegB,
    output logic             stall,
    output logic [31:0]      busy_mask
);

    logic [WIDTH-1:0] r_regs [1:31];
    logic [WIDTH-1:0] w_rd_vec [0:31];
    logic [31:0]      r_busy;
    logic [31:0]      w_busy_next;
    logic             w_wr_valid;
    logic             w_byp_a;
    logic             w_byp_b;
    logic             w_hz_a;
    logic             w_hz_b;

    assign w_wr_valid = ctrl_writeEnable && (ctrl_writeReg != 5'd0);

    // Slot 0 of the read selection is a constant zero, never a storage element.
    assign w_rd_vec[0] = '0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_rd_vec
            assign w_rd_vec[gi] = r_regs[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Clear first, then set, so a fresh issue to the same register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (ctrl_writeEnable) begin
            w_busy_next[ctrl_writeReg] = 1'b0;
        end
        if (sb_set && (sb_setReg != 5'd0)) begin
            w_busy_next[sb_setReg] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign w_byp_a = w_wr_valid && (ctrl_writeReg == ctrl_readRegA);
    assign w_byp_b = w_wr_valid && (ctrl_writeReg == ctrl_readRegB);

    always_comb begin
        data_readRegA = w_rd_vec[ctrl_readRegA];
        data_readRegB = w_rd_vec[ctrl_readRegB];
        if (w_byp_a) begin
            data_readRegA = data_writeReg;
        end
        if (w_byp_b) begin
            data_readRegB = data_writeReg;
        end
    end

    // An operand being written back this cycle is resolved by the bypass.
    assign w_hz_a = (ctrl_readRegA != 5'd0) && r_busy[ctrl_readRegA] && !w_byp_a;
    assign w_hz_b = (ctrl_readRegB != 5'd0) && r_busy[ctrl_readRegB] && !w_byp_b;

    assign stall     = w_hz_a || w_hz_b;
    assign busy_mask = r_busy;

endmodule
`default_nettype wire
